bus_master_port: RTL

- Master-side sequencer for the shared serial bus. It turns one parallel write command (slave select, memory address, data word) into the bus's serial request/select/address/data protocol.
- Handles lost arbitration by retrying, waits for the slave ready/ack, and returns a one-cycle response with error status.
- One instance sits between each master core and the bus arbiter's m1_*/m2_* pins.

---
 rtl/bus_pkg.sv | 34 +++
 rtl/bus_master_port_if.sv | 44 ++++
 rtl/bus_piso.sv | 49 ++++
 rtl/bus_master_port.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial bus master port and its arbiter:
//   - state_t        : sequencer states of bus_master_port
//   - SEL_BITS       : width of the slave select field
//   - SLAVE_*        : slave index constants (SLAVE_INVALID is rejected)
//   - max_int()      : elaboration-time helper for sizing counters
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int SEL_BITS = 2;

    localparam logic [SEL_BITS-1:0] SLAVE_0       = 2'd0;
    localparam logic [SEL_BITS-1:0] SLAVE_1       = 2'd1;
    localparam logic [SEL_BITS-1:0] SLAVE_2       = 2'd2;
    localparam logic [SEL_BITS-1:0] SLAVE_INVALID = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        SEL1,
        SEL0,
        CONN,
        ADDR,
        DATA,
        ACK,
        DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// ---------------------------------------------------------------------------
// bus_master_port_if
// Command/response and serial bus signals of one master port.
//   master modport : the bus_master_port side
//   slave  modport : the core / arbiter side driving commands and bus inputs
// Command: cmd_valid, cmd_ready, cmd_slave, cmd_addr, cmd_data
// Response: rsp_valid, rsp_error
// Bus: bus_request, bus_address_valid, bus_address, bus_data, bus_valid,
//      bus_available, bus_ready
// ---------------------------------------------------------------------------
interface bus_master_port_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    import bus_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [SEL_BITS-1:0]   cmd_slave;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  rsp_valid;
    logic                  rsp_error;
    logic                  bus_request;
    logic                  bus_address_valid;
    logic                  bus_address;
    logic                  bus_data;
    logic                  bus_valid;
    logic                  bus_available;
    logic                  bus_ready;

    modport master (
        input  cmd_valid, cmd_slave, cmd_addr, cmd_data, bus_available, bus_ready,
        output cmd_ready, rsp_valid, rsp_error, bus_request, bus_address_valid,
               bus_address, bus_data, bus_valid
    );

    modport slave (
        output cmd_valid, cmd_slave, cmd_addr, cmd_data, bus_available, bus_ready,
        input  cmd_ready, rsp_valid, rsp_error, bus_request, bus_address_valid,
               bus_address, bus_data, bus_valid
    );

endinterface

// File: rtl/bus_piso.sv
// ---------------------------------------------------------------------------
// bus_piso
// Loadable parallel-in serial-out shifter, MSB first.
//   clk, reset : clock and synchronous active-high reset (control only)
//   i_load     : capture i_data; its MSB appears on o_bit
//   i_data     : parallel word
//   i_shift    : advance to the next lower bit
//   o_bit      : current serial bit
//   o_done     : the bit on o_bit is the last one of the word
// ---------------------------------------------------------------------------
module bus_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift,
    output logic             o_bit,
    output logic             o_done
);
    localparam int LEFT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]  r_shift;
    logic [LEFT_W-1:0] r_left;

    // r_left counts the bits still queued behind the one on o_bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_left <= '0;
        end else if (i_load) begin
            r_left <= LEFT_W'(WIDTH - 1);
        end else if (i_shift && (r_left != '0)) begin
            r_left <= r_left - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= r_shift << 1;
        end
    end

    assign o_bit  = r_shift[WIDTH-1];
    assign o_done = (r_left == '0);

endmodule

// File: rtl/bus_master_port.sv
// ---------------------------------------------------------------------------
// bus_master_port
// Master-side sequencer for the shared serial bus. Converts one parallel
// write command into request / select / address / data serial traffic,
// retries lost arbitration, waits for the slave ack and returns a one-cycle
// response with error status.
//   clk, reset : clock, synchronous active-high reset
//   bus        : bus_master_port_if.master (command, response, bus pins)
// All outputs are registered: each is computed from the state being entered,
// so the value seen during a state belongs to that state.
// ---------------------------------------------------------------------------
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    bus_master_port_if.master  bus
);
    localparam int CNT_W = (max_int(ADDR_WIDTH, DATA_WIDTH) > 1) ?
                           $clog2(max_int(ADDR_WIDTH, DATA_WIDTH)) : 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    state_t              r_state, w_state_next;
    logic [SEL_BITS-1:0] r_slave;
    logic [CNT_W-1:0]    r_cnt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_inc;
    logic                w_err, w_accept;

    logic r_cmd_ready, r_rsp_valid, r_rsp_error, r_bus_request;
    logic r_bus_address_valid, r_bus_address, r_bus_data, r_bus_valid;
    logic w_cmd_ready, w_rsp_valid, w_rsp_error, w_bus_request;
    logic w_bus_address_valid, w_bus_address, w_bus_data, w_bus_valid;

    logic w_addr_bit, w_addr_done, w_addr_shift;
    logic w_data_bit, w_data_done, w_data_shift;

    assign w_accept  = (r_state == IDLE) && bus.cmd_valid;
    assign w_tmo_inc = r_tmo + 1'b1;

    // A shifter advances when its current bit is being registered onto the
    // bus line, and stops once its last bit has been reached.
    assign w_addr_shift = (w_state_next == ADDR) && !w_addr_done;
    assign w_data_shift = (w_state_next == DATA) && !w_data_done;

    bus_piso #(.WIDTH(ADDR_WIDTH)) u_addr_piso (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_data  (bus.cmd_addr),
        .i_shift (w_addr_shift),
        .o_bit   (w_addr_bit),
        .o_done  (w_addr_done)
    );

    bus_piso #(.WIDTH(DATA_WIDTH)) u_data_piso (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_data  (bus.cmd_data),
        .i_shift (w_data_shift),
        .o_bit   (w_data_bit),
        .o_done  (w_data_done)
    );

    always_comb begin
        w_state_next        = r_state;
        w_err               = 1'b0;
        w_cmd_ready         = 1'b0;
        w_rsp_valid         = 1'b0;
        w_rsp_error         = 1'b0;
        w_bus_request       = 1'b0;
        w_bus_address_valid = 1'b0;
        w_bus_address       = 1'b0;
        w_bus_data          = 1'b0;
        w_bus_valid         = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_slave == SLAVE_INVALID) begin
                        w_state_next = DONE;
                        w_err        = 1'b1;
                    end else begin
                        w_state_next = REQ;
                    end
                end
            end
            REQ:  if (bus.bus_available) w_state_next = SEL1;
            // Losing the bus during the first select bit means the other
            // master won; restart selection from REQ.
            SEL1: w_state_next = bus.bus_available ? SEL0 : REQ;
            SEL0: w_state_next = CONN;
            CONN: w_state_next = ADDR;
            ADDR: if (r_cnt == CNT_W'(ADDR_WIDTH - 1)) w_state_next = DATA;
            DATA: if (r_cnt == CNT_W'(DATA_WIDTH - 1)) w_state_next = ACK;
            ACK: begin
                if (bus.bus_ready) begin
                    w_state_next = DONE;
                end else if (w_tmo_inc == TMO_W'(ACK_TIMEOUT)) begin
                    w_state_next = DONE;
                    w_err        = 1'b1;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        case (w_state_next)
            IDLE: w_cmd_ready = 1'b1;
            REQ: begin
                w_bus_request       = 1'b1;
                w_bus_address_valid = 1'b1;
            end
            SEL1: begin
                w_bus_request = 1'b1;
                w_bus_address = r_slave[1];
            end
            SEL0: begin
                w_bus_request = 1'b1;
                w_bus_address = r_slave[0];
            end
            CONN: w_bus_request = 1'b1;
            ADDR: begin
                w_bus_request = 1'b1;
                w_bus_valid   = 1'b1;
                w_bus_address = w_addr_bit;
            end
            DATA: begin
                w_bus_request = 1'b1;
                w_bus_valid   = 1'b1;
                w_bus_data    = w_data_bit;
            end
            ACK:  w_bus_request = 1'b1;
            DONE: begin
                w_rsp_valid = 1'b1;
                w_rsp_error = w_err;
            end
            default: w_cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= IDLE;
            r_cnt               <= '0;
            r_tmo               <= '0;
            r_cmd_ready         <= 1'b1;
            r_rsp_valid         <= 1'b0;
            r_rsp_error         <= 1'b0;
            r_bus_request       <= 1'b0;
            r_bus_address_valid <= 1'b0;
            r_bus_address       <= 1'b0;
            r_bus_data          <= 1'b0;
            r_bus_valid         <= 1'b0;
        end else begin
            r_state             <= w_state_next;
            r_cmd_ready         <= w_cmd_ready;
            r_rsp_valid         <= w_rsp_valid;
            r_rsp_error         <= w_rsp_error;
            r_bus_request       <= w_bus_request;
            r_bus_address_valid <= w_bus_address_valid;
            r_bus_address       <= w_bus_address;
            r_bus_data          <= w_bus_data;
            r_bus_valid         <= w_bus_valid;
            // Both counters restart on every state change.
            if (w_state_next != r_state) begin
                r_cnt <= '0;
                r_tmo <= '0;
            end else begin
                if (r_state == ADDR || r_state == DATA) r_cnt <= r_cnt + 1'b1;
                if (r_state == ACK)                     r_tmo <= w_tmo_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_slave <= bus.cmd_slave;
    end

    assign bus.cmd_ready         = r_cmd_ready;
    assign bus.rsp_valid         = r_rsp_valid;
    assign bus.rsp_error         = r_rsp_error;
    assign bus.bus_request       = r_bus_request;
    assign bus.bus_address_valid = r_bus_address_valid;
    assign bus.bus_address       = r_bus_address;
    assign bus.bus_data          = r_bus_data;
    assign bus.bus_valid         = r_bus_valid;

endmodule
